signed_vector_cross_product_pipe: RTL



---
 rtl/signed_vector_cross_product_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/signed_vector_cross_product_pipe.sv
// -----------------------------------------------------------------------------
// signed_vector_cross_product_pipe
//
// Pipelined signed 3-component cross product with fixed-point scaling.
// A pair of packed vectors {x,y,z} (x in the MSBs) is accepted per cycle over
// a valid/ready handshake. The result {cx,cy,cz} appears three cycles later.
// Each component is arithmetic-shifted right by FRAC_W, with optional
// round-half-up. It is then saturated (SAT_EN=1) or wrapped (SAT_EN=0) to
// COMP_W bits. A per-component flag marks values that did not fit.
//
// Pipeline: S1 input regs -> S2 six products -> S3 scaled differences (outputs).
// When the output is held by backpressure, the whole pipe freezes.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready low during reset or stall)
//   in_vector_1/2       {x,y,z} signed operands, 3*COMP_W bits
//   out_valid/out_ready output handshake
//   out_vector          {cx,cy,cz}, 3*COMP_W bits
//   out_ovf             {ovf_x,ovf_y,ovf_z}
// -----------------------------------------------------------------------------

// One output component: a product pair (S2) and its scaled difference (S3).
// The component is ai*bj - aj*bi.
module svcp_lane #(
    parameter int COMP_W   = 19,
    parameter int FRAC_W   = 0,
    parameter int ROUND_EN = 0,
    parameter int SAT_EN   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_prod_i,
    input  logic                     ld_res_i,
    input  logic signed [COMP_W-1:0] ai_i,
    input  logic signed [COMP_W-1:0] bj_i,
    input  logic signed [COMP_W-1:0] aj_i,
    input  logic signed [COMP_W-1:0] bi_i,
    output logic        [COMP_W-1:0] res_o,
    output logic                     ovf_o
);
    localparam int PW = 2 * COMP_W;   // product width
    localparam int DW = PW + 1;       // exact difference width

    // The extra top bit keeps the rounding add from overflowing.
    localparam logic signed [DW:0] BIAS =
        (ROUND_EN != 0 && FRAC_W > 0) ? ((DW+1)'(1) << ((FRAC_W > 0) ? FRAC_W - 1 : 0)) : '0;
    localparam logic signed [DW:0] MAXV = {{(DW+2-COMP_W){1'b0}}, {(COMP_W-1){1'b1}}};
    localparam logic signed [DW:0] MINV = {{(DW+2-COMP_W){1'b1}}, {(COMP_W-1){1'b0}}};

    logic signed [PW-1:0] ai_x, bj_x, aj_x, bi_x;
    logic signed [PW-1:0] p0_q, p1_q;
    logic signed [DW-1:0] diff;
    logic signed [DW:0]   rnd_v, shifted;
    logic                 hi, lo;
    logic [COMP_W-1:0]    res_d, res_q;
    logic                 ovf_d, ovf_q;

    // Operands are sign-extended first, so the product uses the full 2*COMP_W width.
    assign ai_x = {{COMP_W{ai_i[COMP_W-1]}}, ai_i};
    assign bj_x = {{COMP_W{bj_i[COMP_W-1]}}, bj_i};
    assign aj_x = {{COMP_W{aj_i[COMP_W-1]}}, aj_i};
    assign bi_x = {{COMP_W{bi_i[COMP_W-1]}}, bi_i};

    always_ff @(posedge clk) begin
        if (ld_prod_i) begin
            p0_q <= ai_x * bj_x;
            p1_q <= aj_x * bi_x;
        end
    end

    assign diff    = {p0_q[PW-1], p0_q} - {p1_q[PW-1], p1_q};
    assign rnd_v   = {diff[DW-1], diff} + BIAS;
    assign shifted = rnd_v >>> FRAC_W;

    always_comb begin
        hi    = shifted > MAXV;
        lo    = shifted < MINV;
        ovf_d = hi | lo;
        res_d = shifted[COMP_W-1:0];
        if (SAT_EN != 0) begin
            if (hi)      res_d = MAXV[COMP_W-1:0];
            else if (lo) res_d = MINV[COMP_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (ld_res_i) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign res_o = res_q;
    assign ovf_o = ovf_q;
endmodule

module signed_vector_cross_product_pipe #(
    parameter int COMP_W   = 19,
    parameter int FRAC_W   = 0,
    parameter int ROUND_EN = 0,
    parameter int SAT_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*COMP_W-1:0]   in_vector_1,
    input  logic [3*COMP_W-1:0]   in_vector_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*COMP_W-1:0]   out_vector,
    output logic [2:0]            out_ovf
);
    localparam int STAGES = 3;

    logic                     stall, adv, accept;
    logic [STAGES:1]          vld_pipe_q, vld_pipe_d;
    logic signed [COMP_W-1:0] a_q [3];
    logic signed [COMP_W-1:0] b_q [3];
    logic [2:0][COMP_W-1:0]   res;
    logic [2:0]               ovf;

    assign stall    = vld_pipe_q[STAGES] & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~rst & ~stall;
    assign accept   = in_valid & in_ready;

    // Bubbles move with the data; nothing is compressed while stalled.
    assign vld_pipe_d = adv ? {vld_pipe_q[STAGES-1:1], accept} : vld_pipe_q;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    // S1: component 0 = x (MSBs), 1 = y, 2 = z.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 3; k++) begin
                a_q[k] <= in_vector_1[3*COMP_W-1-k*COMP_W -: COMP_W];
                b_q[k] <= in_vector_2[3*COMP_W-1-k*COMP_W -: COMP_W];
            end
        end
    end

    // Component k = a[(k+1)%3]*b[(k+2)%3] - a[(k+2)%3]*b[(k+1)%3],
    // giving y1z2-z1y2, z1x2-x1z2 and x1y2-y1x2.
    for (genvar k = 0; k < 3; k++) begin : g_lane
        svcp_lane #(
            .COMP_W   (COMP_W),
            .FRAC_W   (FRAC_W),
            .ROUND_EN (ROUND_EN),
            .SAT_EN   (SAT_EN)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .ld_prod_i (adv & vld_pipe_q[1]),
            .ld_res_i  (adv & vld_pipe_q[2]),
            .ai_i      (a_q[(k+1)%3]),
            .bj_i      (b_q[(k+2)%3]),
            .aj_i      (a_q[(k+2)%3]),
            .bi_i      (b_q[(k+1)%3]),
            .res_o     (res[k]),
            .ovf_o     (ovf[k])
        );
    end

    assign out_valid  = vld_pipe_q[STAGES];
    assign out_vector = {res[0], res[1], res[2]};
    assign out_ovf    = {ovf[0], ovf[1], ovf[2]};
endmodule
